// File: rtl/micro_sequencer.sv
// Microcode sequencer: 16-word control store addressing, branch/call/loop ops,
// a 2-deep return stack and a 4-bit loop counter.
module micro_sequencer (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [17:0] uword,
    input  logic [6:0]  cond,
    output logic [3:0]  mpc,
    output logic [7:0]  ctrl,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [2:0] OP_NEXT  = 3'd0;
    localparam logic [2:0] OP_JUMP  = 3'd1;
    localparam logic [2:0] OP_BRT   = 3'd2;
    localparam logic [2:0] OP_BRF   = 3'd3;
    localparam logic [2:0] OP_CALL  = 3'd4;
    localparam logic [2:0] OP_RET   = 3'd5;
    localparam logic [2:0] OP_LDCNT = 3'd6;
    localparam logic [2:0] OP_DJNZ  = 3'd7;

    state_t      state_reg, state_next;
    logic [3:0]  mpc_reg, mpc_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [1:0]  sp_reg, sp_next;
    logic [3:0]  stack_reg [2];
    logic        busy_reg, done_reg, err_reg;

    logic [2:0]  op;
    logic [2:0]  csel;
    logic [7:0]  control;
    logic [3:0]  target;
    logic [7:0]  cond_ext;
    logic        c;
    logic [3:0]  mpc_inc;
    logic [3:0]  cnt_dec;
    logic [3:0]  pop_val;
    logic        run;
    logic        is_halt;
    logic        is_fault;
    logic        push_en;

    assign op       = uword[17:15];
    assign csel     = uword[14:12];
    assign control  = uword[11:4];
    assign target   = uword[3:0];

    // csel 7 selects a constant 1, so it is appended as the top bit
    assign cond_ext = {1'b1, cond};
    assign c        = cond_ext[csel];

    assign mpc_inc  = mpc_reg + 4'd1;
    assign cnt_dec  = cnt_reg - 4'd1;
    assign pop_val  = (sp_reg == 2'd2) ? stack_reg[1] : stack_reg[0];

    assign run      = (state_reg == S_RUN);
    assign is_halt  = (op == OP_NEXT) && (csel == 3'd7);
    assign is_fault = ((op == OP_CALL) && (sp_reg == 2'd2)) ||
                      ((op == OP_RET)  && (sp_reg == 2'd0));
    assign push_en  = run && (op == OP_CALL) && (sp_reg != 2'd2);

    assign ctrl = (run && !is_halt && !is_fault) ? control : 8'h00;
    assign mpc  = mpc_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;

    always_comb begin
        state_next = state_reg;
        mpc_next   = mpc_reg;
        cnt_next   = cnt_reg;
        sp_next    = sp_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                if (is_fault) begin
                    state_next = S_ERR;
                end else if (is_halt) begin
                    state_next = S_HALT;
                end else begin
                    case (op)
                        OP_NEXT:  mpc_next = mpc_inc;
                        OP_JUMP:  mpc_next = target;
                        OP_BRT:   mpc_next = c ? target : mpc_inc;
                        OP_BRF:   mpc_next = c ? mpc_inc : target;
                        OP_CALL: begin
                            mpc_next = target;
                            sp_next  = sp_reg + 2'd1;
                        end
                        OP_RET: begin
                            mpc_next = pop_val;
                            sp_next  = sp_reg - 2'd1;
                        end
                        OP_LDCNT: begin
                            cnt_next = target;
                            mpc_next = mpc_inc;
                        end
                        default: begin
                            // DJNZ: a zero count wraps to 15 and still branches
                            cnt_next = cnt_dec;
                            mpc_next = (cnt_dec != 4'd0) ? target : mpc_inc;
                        end
                    endcase
                end
            end
            S_HALT: begin
                if (start) begin
                    state_next = S_RUN;
                    mpc_next   = 4'd0;
                    sp_next    = 2'd0;
                end
            end
            default: begin
                state_next = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
            mpc_reg   <= 4'd0;
            cnt_reg   <= 4'd0;
            sp_reg    <= 2'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mpc_reg   <= mpc_next;
            cnt_reg   <= cnt_next;
            sp_reg    <= sp_next;
            busy_reg  <= (state_next == S_RUN);
            done_reg  <= (state_next == S_HALT);
            err_reg   <= (state_next == S_ERR);
        end
    end

    // Each return-stack entry is written only when a push lands on its slot
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stack
            always_ff @(posedge clock) begin
                if (!resetn) begin
                    stack_reg[gi] <= 4'd0;
                end else if (push_en && (sp_reg == 2'(gi))) begin
                    stack_reg[gi] <= mpc_inc;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed-vector bench for micro_sequencer; expected outputs are queued per
// cycle by the stimulus and compared by an independent negedge monitor.
module tb_micro_sequencer;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [17:0] uword;
    logic [6:0]  cond;
    logic [3:0]  mpc;
    logic [7:0]  ctrl;
    logic        busy;
    logic        done;
    logic        err;

    logic [17:0] rom [16];

    typedef struct {
        logic [3:0] mpc;
        logic [7:0] ctrl;
        logic       busy;
        logic       done;
        logic       err;
        int         tag;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    micro_sequencer dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .uword  (uword),
        .cond   (cond),
        .mpc    (mpc),
        .ctrl   (ctrl),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    assign uword = rom[mpc];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [17:0] w(input logic [2:0] op, input logic [2:0] cs,
                                      input logic [7:0] ct, input logic [3:0] tg);
        return {op, cs, ct, tg};
    endfunction

    // Expected values describe the cycle just begun; the inputs apply to its closing edge
    task automatic step(input logic s, input logic rn, input logic [6:0] cv,
                        input logic [3:0] em, input logic [7:0] ec,
                        input logic eb, input logic ed, input logic ee, input int tag);
        exp_t e;
        @(posedge clock);
        #1;
        start  = s;
        resetn = rn;
        cond   = cv;
        e.mpc  = em;
        e.ctrl = ec;
        e.busy = eb;
        e.done = ed;
        e.err  = ee;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (mpc !== e.mpc || ctrl !== e.ctrl || busy !== e.busy ||
                done !== e.done || err !== e.err) begin
                errors++;
                $display("FAIL step%0d: got mpc=%0d ctrl=%02h busy=%b done=%b err=%b, want mpc=%0d ctrl=%02h busy=%b done=%b err=%b",
                         e.tag, mpc, ctrl, busy, done, err,
                         e.mpc, e.ctrl, e.busy, e.done, e.err);
            end else begin
                $display("step%0d ok: mpc=%0d ctrl=%02h busy=%b done=%b err=%b",
                         e.tag, mpc, ctrl, busy, done, err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        start  = 1'b0;
        resetn = 1'b0;
        cond   = 7'd0;
        for (int i = 0; i < 16; i++) rom[i] = 18'd0;
        rom[0] = w(3'd0, 3'd0, 8'h11, 4'd0);
        rom[1] = w(3'd0, 3'd0, 8'h22, 4'd0);
        rom[2] = w(3'd0, 3'd7, 8'hAB, 4'd0);

        // Reset, then NEXT, NEXT, HALT
        step(0, 0, 7'd0, 4'd0,  8'h00, 0, 0, 0, 1);
        step(0, 1, 7'd0, 4'd0,  8'h00, 0, 0, 0, 2);
        step(1, 1, 7'd0, 4'd0,  8'h00, 0, 0, 0, 3);
        step(0, 1, 7'd0, 4'd0,  8'h11, 1, 0, 0, 4);
        step(0, 1, 7'd0, 4'd1,  8'h22, 1, 0, 0, 5);
        step(0, 1, 7'd0, 4'd2,  8'h00, 1, 0, 0, 6);
        step(0, 1, 7'd0, 4'd2,  8'h00, 0, 1, 0, 7);
        step(0, 1, 7'd4, 4'd2,  8'h00, 0, 1, 0, 8);

        // BRT taken / not taken, BRF on constant-true never jumps
        rom[0] = w(3'd2, 3'd2, 8'h33, 4'd9);
        rom[1] = w(3'd0, 3'd7, 8'h00, 4'd0);
        rom[9] = w(3'd0, 3'd7, 8'h00, 4'd0);
        step(1, 1, 7'd4, 4'd2,  8'h00, 0, 1, 0, 9);
        step(0, 1, 7'd4, 4'd0,  8'h33, 1, 0, 0, 10);
        step(0, 1, 7'd4, 4'd9,  8'h00, 1, 0, 0, 11);
        step(0, 1, 7'd0, 4'd9,  8'h00, 0, 1, 0, 12);
        step(1, 1, 7'd0, 4'd9,  8'h00, 0, 1, 0, 13);
        step(0, 1, 7'd0, 4'd0,  8'h33, 1, 0, 0, 14);
        step(0, 1, 7'd0, 4'd1,  8'h00, 1, 0, 0, 15);
        step(0, 1, 7'd0, 4'd1,  8'h00, 0, 1, 0, 16);
        rom[0] = w(3'd3, 3'd7, 8'h44, 4'd9);
        step(1, 1, 7'd0, 4'd1,  8'h00, 0, 1, 0, 17);
        step(0, 1, 7'd0, 4'd0,  8'h44, 1, 0, 0, 18);
        step(0, 1, 7'd0, 4'd1,  8'h00, 1, 0, 0, 19);
        step(0, 1, 7'd0, 4'd1,  8'h00, 0, 1, 0, 20);

        // LDCNT 3 / DJNZ loop: 0,1,1,1,2
        rom[0] = w(3'd6, 3'd0, 8'h55, 4'd3);
        rom[1] = w(3'd7, 3'd0, 8'h66, 4'd1);
        rom[2] = w(3'd0, 3'd7, 8'h00, 4'd0);
        step(1, 1, 7'd0, 4'd1,  8'h00, 0, 1, 0, 21);
        step(0, 1, 7'd0, 4'd0,  8'h55, 1, 0, 0, 22);
        step(0, 1, 7'd0, 4'd1,  8'h66, 1, 0, 0, 23);
        step(0, 1, 7'd0, 4'd1,  8'h66, 1, 0, 0, 24);
        step(0, 1, 7'd0, 4'd1,  8'h66, 1, 0, 0, 25);
        step(0, 1, 7'd0, 4'd2,  8'h00, 1, 0, 0, 26);
        step(0, 1, 7'd0, 4'd2,  8'h00, 0, 1, 0, 27);

        // DJNZ at cnt=0 wraps and branches; JUMP; BRF with false condition jumps
        rom[0]  = w(3'd7, 3'd0, 8'h77, 4'd5);
        rom[5]  = w(3'd1, 3'd0, 8'h88, 4'd8);
        rom[8]  = w(3'd3, 3'd3, 8'h99, 4'd12);
        rom[12] = w(3'd0, 3'd7, 8'h00, 4'd0);
        step(1, 1, 7'd0, 4'd2,  8'h00, 0, 1, 0, 28);
        step(0, 1, 7'd0, 4'd0,  8'h77, 1, 0, 0, 29);
        step(0, 1, 7'd0, 4'd5,  8'h88, 1, 0, 0, 30);
        step(0, 1, 7'd0, 4'd8,  8'h99, 1, 0, 0, 31);
        step(0, 1, 7'd0, 4'd12, 8'h00, 1, 0, 0, 32);
        step(0, 1, 7'd0, 4'd12, 8'h00, 0, 1, 0, 33);

        // CALL at 15 returns to 0; then RET at sp=0 underflows
        rom[0]  = w(3'd2, 3'd0, 8'hA0, 4'd15);
        rom[15] = w(3'd4, 3'd0, 8'hC1, 4'd4);
        rom[4]  = w(3'd5, 3'd0, 8'hC2, 4'd0);
        rom[1]  = w(3'd5, 3'd0, 8'hC3, 4'd0);
        step(1, 1, 7'd0, 4'd12, 8'h00, 0, 1, 0, 34);
        step(0, 1, 7'd1, 4'd0,  8'hA0, 1, 0, 0, 35);
        step(0, 1, 7'd0, 4'd15, 8'hC1, 1, 0, 0, 36);
        step(0, 1, 7'd0, 4'd4,  8'hC2, 1, 0, 0, 37);
        step(0, 1, 7'd0, 4'd0,  8'hA0, 1, 0, 0, 38);
        step(0, 1, 7'd0, 4'd1,  8'h00, 1, 0, 0, 39);
        step(1, 1, 7'd0, 4'd1,  8'h00, 0, 0, 1, 40);
        step(0, 0, 7'd0, 4'd1,  8'h00, 0, 0, 1, 41);
        step(0, 1, 7'd0, 4'd0,  8'h00, 0, 0, 0, 42);

        // Three nested CALLs overflow the stack; ERR ignores start until reset
        rom[0] = w(3'd4, 3'd0, 8'hD0, 4'd3);
        rom[3] = w(3'd4, 3'd0, 8'hD3, 4'd6);
        rom[6] = w(3'd4, 3'd0, 8'hD6, 4'd9);
        step(1, 1, 7'd0, 4'd0,  8'h00, 0, 0, 0, 43);
        step(0, 1, 7'd0, 4'd0,  8'hD0, 1, 0, 0, 44);
        step(0, 1, 7'd0, 4'd3,  8'hD3, 1, 0, 0, 45);
        step(0, 1, 7'd0, 4'd6,  8'h00, 1, 0, 0, 46);
        step(1, 1, 7'd0, 4'd6,  8'h00, 0, 0, 1, 47);
        step(1, 1, 7'd0, 4'd6,  8'h00, 0, 0, 1, 48);
        step(0, 0, 7'd0, 4'd6,  8'h00, 0, 0, 1, 49);
        step(0, 1, 7'd0, 4'd0,  8'h00, 0, 0, 0, 50);

        // Reset mid-loop with cnt=2, sp=1
        rom[0] = w(3'd4, 3'd0, 8'hE0, 4'd2);
        rom[2] = w(3'd6, 3'd0, 8'hE2, 4'd3);
        rom[3] = w(3'd7, 3'd0, 8'hE3, 4'd3);
        step(1, 1, 7'd0, 4'd0,  8'h00, 0, 0, 0, 51);
        step(0, 1, 7'd0, 4'd0,  8'hE0, 1, 0, 0, 52);
        step(0, 1, 7'd0, 4'd2,  8'hE2, 1, 0, 0, 53);
        step(0, 1, 7'd0, 4'd3,  8'hE3, 1, 0, 0, 54);
        step(0, 0, 7'd0, 4'd3,  8'hE3, 1, 0, 0, 55);
        step(0, 1, 7'd0, 4'd0,  8'h00, 0, 0, 0, 56);

        // Cleared cnt: two DJNZs both branch (15, 14); cleared sp: RET underflows
        rom[0] = w(3'd7, 3'd0, 8'hF0, 4'd1);
        rom[1] = w(3'd7, 3'd0, 8'hF1, 4'd5);
        rom[2] = w(3'd0, 3'd7, 8'h00, 4'd0);
        rom[5] = w(3'd5, 3'd0, 8'hF5, 4'd0);
        step(1, 1, 7'd0, 4'd0,  8'h00, 0, 0, 0, 57);
        step(0, 1, 7'd0, 4'd0,  8'hF0, 1, 0, 0, 58);
        step(0, 1, 7'd0, 4'd1,  8'hF1, 1, 0, 0, 59);
        step(0, 1, 7'd0, 4'd5,  8'h00, 1, 0, 0, 60);
        step(0, 1, 7'd0, 4'd5,  8'h00, 0, 0, 1, 61);

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, rising-edge; all state updates on this edge.
REQ-002 SHALL have: resetn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: start  in  1  begin execution from address 0 (sampled in IDLE and HALT only).
REQ-004 SHALL have: uword  in  18  microinstruction from control store at current mpc, combinational.
REQ-005 SHALL have: cond  in  7  condition flags from datapath.
REQ-006 SHALL have: mpc  out  4  registered micro-program counter, drives control-store address.
REQ-007 SHALL have: ctrl  out  8  datapath control field for the current microinstruction.
REQ-008 SHALL have: busy  out  1  high in RUN; done  out  1  high in HALT; err  out  1  high in ERR.

Function
REQ-009 SHALL decode uword as: [17:15] op, [14:12] csel, [11:4] control, [3:0] target.
REQ-010 SHALL select condition c = cond[csel] for csel 0..6; c = 1 for csel 7.
REQ-011 SHALL implement FSM states IDLE, RUN, HALT, ERR.
REQ-012 IDLE: mpc held 0; start=1 -> RUN next edge; mpc stays 0.
REQ-013 RUN: one microinstruction per cycle; next mpc per op below; ctrl = uword[11:4], combinational.
REQ-014 ctrl SHALL be 0 in IDLE, HALT, ERR, and on the HALT word's own cycle.
REQ-015 op 0 NEXT: mpc <= mpc+1; if csel=7 it is HALT instead: state -> HALT, mpc holds.
REQ-016 op 1 JUMP: mpc <= target.
REQ-017 op 2 BRT: mpc <= c ? target : mpc+1.
REQ-018 op 3 BRF: mpc <= c ? mpc+1 : target.
REQ-019 op 4 CALL: push mpc+1 onto return stack; mpc <= target.
REQ-020 op 5 RET: pop; mpc <= popped value.
REQ-021 op 6 LDCNT: loop counter cnt (4 bits) <= target; mpc <= mpc+1.
REQ-022 op 7 DJNZ: cnt <= cnt-1 (mod 16); mpc <= (cnt-1 != 0) ? target : mpc+1.
REQ-023 All mpc+1 arithmetic SHALL be mod 16; 15+1 = 0, including CALL's pushed return address.
REQ-024 Return stack SHALL be 2 entries, LIFO, pointer sp 0..2.
REQ-025 CALL with sp=2 (overflow) or RET with sp=0 (underflow): state -> ERR, mpc, stack, cnt hold; ctrl=0 that cycle.
REQ-026 ERR SHALL be exited only by reset; start ignored.
REQ-027 HALT: start=1 -> RUN, mpc <= 0, sp <= 0; cnt preserved.
REQ-028 start SHALL be ignored while in RUN.
REQ-029 cond SHALL be sampled in the same cycle as the branch word (no pipeline); next mpc visible one edge later.
REQ-030 DJNZ with cnt=0 SHALL wrap cnt to 15 and take the branch.

Reset
REQ-031 resetn=0 at a rising edge SHALL force state IDLE, mpc=0, sp=0, cnt=0, stack entries=0, regardless of current state, including mid-RUN.
REQ-032 During and after reset until start: ctrl=0, busy=0, done=0, err=0.

Verification
REQ-033 Reset, start pulse, store words 0:NEXT ctrl=0x11, 1:NEXT ctrl=0x22, 2:HALT -> mpc 0,1,2 on successive RUN cycles; ctrl 0x11,0x22,0x00; done=1 from cycle after word 2; mpc stays 2.
REQ-034 Word 0: BRT csel=2 target=9; cond[2]=1 -> mpc=9; rerun with cond[2]=0 -> mpc=1; BRF csel=7 -> never jumps.
REQ-035 Word 0: LDCNT target=3; word 1: DJNZ target=1 -> mpc sequence 0,1,1,1,2; cnt ends 0.
REQ-036 Word 15: CALL target=4; word 4: RET -> mpc 15,4,0 (return wraps to 0); sp back to 0.
REQ-037 Three nested CALLs without RET -> err=1 on third CALL, ctrl=0, mpc frozen; start ignored; resetn=0 -> IDLE, mpc=0, err=0. RET at sp=0 -> err=1.
REQ-038 resetn=0 asserted mid-loop (cnt=2, sp=1) -> next edge mpc=0, busy=0, sp=0, cnt=0.
